// File: rtl/state_control.sv
// Touch-panel vending controller: decodes touch presses into buttons and runs the select/pay/change FSM.
// Latency: one cycle from the first nonzero touch_data sample to the updated state, money and point_flag.
// Backpressure: none. Every sample is evaluated, and a held touch counts as a single press.
module state_control #(
    parameter logic [6:0] PRICE0 = 7'd3,
    parameter logic [6:0] PRICE1 = 7'd4,
    parameter logic [6:0] PRICE2 = 7'd10,
    parameter logic [6:0] PRICE3 = 7'd15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] touch_data,
    output logic        point_flag,
    output logic [6:0]  money
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        BTN_NONE,
        BTN_ITEM0,
        BTN_ITEM1,
        BTN_ITEM2,
        BTN_ITEM3,
        BTN_COIN1,
        BTN_COIN5,
        BTN_COIN10,
        BTN_CONFIRM,
        BTN_CANCEL
    } btn_t;

    state_t      state;
    logic [6:0]  price;
    logic        prev_touch;

    logic [15:0] x;
    logic [15:0] y;
    logic        touching;
    logic        press;
    btn_t        btn;
    logic        is_item;
    logic        is_coin;
    logic [6:0]  item_price;
    logic [3:0]  coin_val;
    logic [7:0]  coin_sum;
    logic [6:0]  money_add;

    assign x        = touch_data[31:16];
    assign y        = touch_data[15:0];
    assign touching = (touch_data != 32'd0);
    assign press    = touching && !prev_touch;

    // Map the touch coordinate onto a button region (all bounds inclusive).
    always_comb begin
        btn = BTN_NONE;
        if (y >= 16'd50 && y <= 16'd149) begin
            if (x <= 16'd199)                    btn = BTN_ITEM0;
            else if (x <= 16'd399)               btn = BTN_ITEM1;
        end else if (y >= 16'd150 && y <= 16'd249) begin
            if (x <= 16'd199)                    btn = BTN_ITEM2;
            else if (x <= 16'd399)               btn = BTN_ITEM3;
        end
        if (y >= 16'd50 && y <= 16'd119) begin
            if (x >= 16'd600 && x <= 16'd679)      btn = BTN_COIN1;
            else if (x >= 16'd680 && x <= 16'd759) btn = BTN_COIN5;
            else if (x >= 16'd760 && x <= 16'd799) btn = BTN_COIN10;
        end
        if (x >= 16'd600 && x <= 16'd759) begin
            if (y >= 16'd200 && y <= 16'd279)      btn = BTN_CONFIRM;
            else if (y >= 16'd290 && y <= 16'd349) btn = BTN_CANCEL;
        end
    end

    // Derive the item price and the saturating coin-added balance for the decoded button.
    always_comb begin
        is_item    = 1'b0;
        is_coin    = 1'b0;
        item_price = PRICE0;
        coin_val   = 4'd0;
        case (btn)
            BTN_ITEM0:  begin is_item = 1'b1; item_price = PRICE0; end
            BTN_ITEM1:  begin is_item = 1'b1; item_price = PRICE1; end
            BTN_ITEM2:  begin is_item = 1'b1; item_price = PRICE2; end
            BTN_ITEM3:  begin is_item = 1'b1; item_price = PRICE3; end
            BTN_COIN1:  begin is_coin = 1'b1; coin_val = 4'd1; end
            BTN_COIN5:  begin is_coin = 1'b1; coin_val = 4'd5; end
            BTN_COIN10: begin is_coin = 1'b1; coin_val = 4'd10; end
            default:    ;
        endcase
        coin_sum  = {1'b0, money} + {4'd0, coin_val};
        money_add = coin_sum[7] ? 7'd127 : coin_sum[6:0];
    end

    // Select/pay/change FSM with registered money and press pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            price      <= 7'd0;
            money      <= 7'd0;
            point_flag <= 1'b0;
            prev_touch <= 1'b0;
        end else begin
            prev_touch <= touching;
            point_flag <= 1'b0;
            if (press && btn != BTN_NONE) begin
                case (state)
                    IDLE: begin
                        // Only item selection starts a transaction.
                        if (is_item) begin
                            price      <= item_price;
                            money      <= 7'd0;
                            state      <= PAY;
                            point_flag <= 1'b1;
                        end
                    end
                    PAY: begin
                        point_flag <= 1'b1;
                        if (is_item) begin
                            price <= item_price;
                        end else if (is_coin) begin
                            money <= money_add;
                        end else if (btn == BTN_CONFIRM) begin
                            // Short balance: pulse only, stay in PAY.
                            if (money >= price) begin
                                money <= money - price;
                                state <= DONE;
                            end
                        end else begin
                            money <= 7'd0;
                            state <= IDLE;
                        end
                    end
                    DONE: begin
                        money      <= 7'd0;
                        state      <= IDLE;
                        point_flag <= 1'b1;
                    end
                    default: begin
                        money <= 7'd0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_state_control.sv
module tb_state_control;

    logic        clk;
    logic        rstn;
    logic [31:0] touch_data;
    logic        point_flag;
    logic [6:0]  money;

    int n_checks;
    int n_errors;

    localparam int S_IDLE = 0;
    localparam int S_PAY  = 1;
    localparam int S_DONE = 2;

    state_control dut (
        .clk        (clk),
        .rstn       (rstn),
        .touch_data (touch_data),
        .point_flag (point_flag),
        .money      (money)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle touch at (x,y), then one idle cycle; checks the pulse, balance and state.
    task automatic tap(input string tag, input int x, input int y,
                       input int exp_flag, input int exp_money, input int exp_state);
        touch_data = {x[15:0], y[15:0]};
        step();
        check({tag, ".flag"},  int'(point_flag), exp_flag);
        check({tag, ".money"}, int'(money),      exp_money);
        check({tag, ".state"}, int'(dut.state),  exp_state);
        touch_data = 32'd0;
        step();
        check({tag, ".flag_off"}, int'(point_flag), 0);
    endtask

    initial begin
        int exp_m;
        n_checks   = 0;
        n_errors   = 0;
        rstn       = 1'b0;
        touch_data = 32'd0;

        // 1: reset, then a coin in IDLE is ignored
        step();
        step();
        check("rst.money", int'(money),      0);
        check("rst.flag",  int'(point_flag), 0);
        check("rst.state", int'(dut.state),  S_IDLE);
        rstn = 1'b1;
        step();
        tap("idle_coin", 617, 85, 0, 0, S_IDLE);
        tap("idle_blank", 500, 500, 0, 0, S_IDLE);

        // 2: select item 0, then reselect item 1
        tap("item0", 20, 100, 1, 0, S_PAY);
        check("item0.price", int'(dut.price), 3);
        tap("item1", 315, 100, 1, 0, S_PAY);
        check("item1.price", int'(dut.price), 4);

        // 3: coins and short-balance confirms
        tap("coin1_a",   617, 85,  1, 1, S_PAY);
        tap("confirm_a", 630, 250, 1, 1, S_PAY);
        tap("coin1_b",   617, 85,  1, 2, S_PAY);
        tap("confirm_b", 630, 250, 1, 2, S_PAY);
        tap("pay_blank", 500, 500, 0, 2, S_PAY);

        // 4: enough money, change, then any press back to IDLE
        tap("coin5",     710, 85,  1, 7, S_PAY);
        tap("confirm_c", 630, 250, 1, 3, S_DONE);
        tap("done_any",  630, 250, 1, 0, S_IDLE);

        // 5: saturation at 127, then cancel
        tap("item0_b", 20, 100, 1, 0, S_PAY);
        exp_m = 0;
        for (int i = 0; i < 13; i++) begin
            exp_m = (exp_m + 10 > 127) ? 127 : exp_m + 10;
            tap($sformatf("coin10_%0d", i), 780, 85, 1, exp_m, S_PAY);
        end
        tap("cancel", 630, 320, 1, 0, S_IDLE);

        // 6: held touch yields one press; reset mid-transaction
        tap("item2", 50, 200, 1, 0, S_PAY);
        check("item2.price", int'(dut.price), 10);
        touch_data = {16'd617, 16'd85};
        step();
        check("hold.flag0",  int'(point_flag), 1);
        check("hold.money0", int'(money),      1);
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("hold.flag%0d", i),  int'(point_flag), 0);
            check($sformatf("hold.money%0d", i), int'(money),      1);
        end
        touch_data = 32'd0;
        step();
        check("hold.release", int'(point_flag), 0);
        rstn = 1'b0;
        step();
        check("midrst.state", int'(dut.state),  S_IDLE);
        check("midrst.money", int'(money),      0);
        check("midrst.flag",  int'(point_flag), 0);
        rstn = 1'b1;
        step();
        tap("post_rst_coin", 617, 85, 0, 0, S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/state_control.md
Name: state_control

Overview:
- Touch-panel vending controller.
- Takes raw touch coordinates from the touch-screen front end and decodes presses into button hits.
- Runs a select/pay/change state machine and reports the current money balance for the display layer.
- `point_flag` marks each accepted button press, for click feedback or a UI refresh.

Parameters:
- PRICE0, 3, price of item 0
- PRICE1, 4, price of item 1
- PRICE2, 10, price of item 2
- PRICE3, 15, price of item 3

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous active-low reset
- touch_data  input  32  [31:16] = x, [15:0] = y, unsigned pixel coordinates; all-zero = no touch
- point_flag  output  1  one-cycle pulse per accepted press
- money  output  7  current balance (PAY) or change (DONE); unsigned

Behaviour:
- Reset and registering:
  - All logic is on the rising edge of clk.
  - While rstn = 0: state = IDLE, money = 0, point_flag = 0, touch history = 0.
- Press detection:
  - Keep a registered flag `prev_touch = (touch_data != 0)`.
  - press = (touch_data != 0) && !prev_touch.
  - One press per touch; a one-cycle touch must be caught.
  - A held touch gives only one press.
- Button regions (inclusive bounds; x then y):
  - ITEM0: x 0..199, y 50..149
  - ITEM1: x 200..399, y 50..149
  - ITEM2: x 0..199, y 150..249
  - ITEM3: x 200..399, y 150..249
  - COIN1: x 600..679, y 50..119
  - COIN5: x 680..759, y 50..119
  - COIN10: x 760..799, y 50..119
  - CONFIRM: x 600..759, y 200..279
  - CANCEL: x 600..759, y 290..349
  - Anything else is no button.
- Internal registers: state (IDLE/PAY/DONE) and price (7 bits).
- IDLE:
  - ITEMn → price = PRICEn, money = 0, go to PAY.
  - All other buttons are ignored (not accepted).
- PAY:
  - ITEMn → price = PRICEn (reselect); money unchanged.
  - COINk → money = min(money + k, 127); saturates at 127, no wrap.
  - CONFIRM with money ≥ price → money = money − price, go to DONE.
  - CONFIRM with money < price → accepted, but no state or money change.
  - CANCEL → money = 0, go to IDLE.
- DONE:
  - Any button press → money = 0, go to IDLE.
- Timing:
  - The press is evaluated in the cycle where it is detected.
  - state, money and point_flag update at that clock edge, so they are visible one cycle after touch_data goes nonzero.
  - point_flag = 1 for exactly one cycle on every accepted press, including an insufficient-funds CONFIRM.
  - point_flag = 0 for ignored presses and non-button touches.
- Reset mid-transaction returns to IDLE with money = 0.

Test Plan:
1. Reset with rstn = 0 for 2 cycles, then release → money = 0, point_flag = 0; a press at (617,85) is ignored (IDLE, no pulse).
2. (20,100) then (315,100) as one-cycle pulses separated by zeros:
   - Each press gives one point_flag pulse.
   - End state is PAY, price = 4, money = 0.
3. Continuing from 2, pulse sequence (617,85), (630,250), (617,85), (630,250):
   - money goes 1, 1, 2, 2; both CONFIRMs pulse point_flag, state stays PAY.
4. Continuing from 3, pulse sequence (710,85), (630,250):
   - money 7, then 3 (change); state DONE.
   - Next press (630,250) → money 0, state IDLE.
5. In PAY, press COIN10 13 times → money saturates at 127. Then press (630,320) → money 0, IDLE.
6. Hold touch_data = {16'd617, 16'd85} for 5 cycles while in PAY → exactly one point_flag pulse and money +1.
   - Also assert rstn = 0 while in PAY → IDLE, money 0 on the next edge.
